// File: rtl/dmem_bus_pkg.sv
// dmem_bus_pkg: shared FSM state, funct3 encodings and timeout default for the data-memory bus bridge
package dmem_bus_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam int TIMEOUT_CYCLES_DEF = 255;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: RV32 access legality, byte enables, store replication and load extension
module lsu_lane_align import dmem_bus_pkg::*; (
    input  logic [2:0]  funct3,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [31:0] sh;
    always_comb begin
        legal     = (funct3 == F3_B || funct3 == F3_BU) ? 1'b1 :
                    (funct3 == F3_H || funct3 == F3_HU) ? !lo[0] :
                    (funct3 == F3_W) ? (lo == 2'b00) : 1'b0;
        be        = (funct3[1:0] == 2'd0) ? 4'b0001 << lo :
                    (funct3[1:0] == 2'd1) ? 4'b0011 << lo : 4'b1111;
        wdata_rep = (funct3[1:0] == 2'd0) ? {4{wdata[7:0]}} :
                    (funct3[1:0] == 2'd1) ? {2{wdata[15:0]}} : wdata;
        sh        = rdata >> {lo, 3'b000};
        rdata_ext = (funct3 == F3_B)  ? {{24{sh[7]}}, sh[7:0]} :
                    (funct3 == F3_BU) ? {24'b0, sh[7:0]} :
                    (funct3 == F3_H)  ? {{16{sh[15]}}, sh[15:0]} :
                    (funct3 == F3_HU) ? {16'b0, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: stalls the core while its load/store runs as a valid/ready bus transaction; BUS_TIMEOUT_EN adds a BUSY timeout
module dmem_bus_bridge import dmem_bus_pkg::*; #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [2:0]        cpu_funct3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
);
    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rdata_ext;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
    end

    // In BUSY the lane logic works on the captured request so the load extension matches what was issued
    lsu_lane_align u_align (
        .funct3    (state == IDLE ? cpu_funct3 : f3_q),
        .lo        (state == IDLE ? cpu_addr[1:0] : lo_q),
        .wdata     (cpu_wdata),
        .rdata     (bus_rdata),
        .legal     (legal),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    assign cpu_stall = (state == BUSY) || (state == IDLE && (cpu_rd || cpu_wr));

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0;
            bus_wdata <= 32'b0;
            cpu_rdata <= 32'b0;
            cpu_err   <= 1'b0;
            f3_q      <= 3'b0;
            lo_q      <= 2'b0;
`ifdef BUS_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            cpu_err <= 1'b0;
            case (state)
                IDLE: if (cpu_rd || cpu_wr) begin
                    if ((cpu_rd && cpu_wr) || !legal) begin
                        state     <= ERR;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= 32'b0;
                    end else begin
                        state     <= BUSY;
                        bus_valid <= 1'b1;
                        bus_we    <= cpu_wr;
                        bus_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= be;
                        bus_wdata <= wdata_rep;
                        f3_q      <= cpu_funct3;
                        lo_q      <= cpu_addr[1:0];
`ifdef BUS_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                BUSY: if (bus_ready) begin
                    state     <= DONE;
                    bus_valid <= 1'b0;
                    cpu_rdata <= rdata_ext;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state     <= ERR;
                    bus_valid <= 1'b0;
                    cpu_err   <= 1'b1;
                    cpu_rdata <= 32'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the single-cycle core's memory stage, in place of the zero-latency data memory.
- Converts the core's MemRead/MemWrite strobes, ALU address and store data into a registered valid/ready bus transaction with RV32 byte/half/word lane handling.
- Stalls the core until the access completes; load data goes back to the writeback mux, sign- or zero-extended.

Parameters:
- ADDR_W, 32, width of cpu_addr and bus_addr.
- TIMEOUT_CYCLES, 255, BUSY cycles without bus_ready before an error (used only with BUS_TIMEOUT_EN); must be ≥1.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_rd  in  1  load request (core MemRead).
- cpu_wr  in  1  store request (core MemWrite).
- cpu_funct3  in  3  Inst[14:12]: size/sign of access.
- cpu_addr  in  ADDR_W  byte address (ALU result).
- cpu_wdata  in  32  store data (rs2).
- cpu_rdata  out  32  extended load data, valid while cpu_stall=0 in DONE.
- cpu_stall  out  1  hold PC and register write.
- cpu_err  out  1  one-cycle pulse: misaligned, illegal or timed-out access.
- bus_valid  out  1  request valid (registered).
- bus_we  out  1  1=write.
- bus_addr  out  ADDR_W  word-aligned address, addr[1:0]=0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ready  in  1  completion; bus_rdata valid same cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; bus_valid, bus_we, bus_be, bus_addr, bus_wdata = 0.
  - cpu_rdata=0, cpu_err=0, timeout counter=0.
  - Reset mid-transaction abandons it; bus_valid drops without waiting for bus_ready.
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - cpu_stall = (cpu_rd|cpu_wr), combinational.
  - Legal, aligned request → register bus_* outputs, go to BUSY.
  - Misaligned, both strobes high, or undefined funct3 → go to ERR with no bus transaction.
- BUSY:
  - bus_valid=1; bus_* held stable; cpu_stall=1.
  - On bus_ready: capture extended read data into cpu_rdata, drop bus_valid, go to DONE.
- DONE: cpu_stall=0 for exactly one cycle; core commits; go to IDLE unconditionally (never re-issues the same request).
- ERR:
  - cpu_stall=0, cpu_err=1, cpu_rdata=0 for one cycle, then IDLE.
  - For stores, no write reaches the bus.
- Latency: with bus_ready high in the first BUSY cycle, the request cycle and the BUSY cycle are stalled; DONE is cycle 2. Each bus wait state adds one cycle.
- Alignment:
  - LB/LBU/SB: any address.
  - LH/LHU/SH: addr[0]=0.
  - LW/SW: addr[1:0]=0.
  - funct3 3, 6, 7 are illegal.
- Byte enables:
  - SB/LB: be = 1 << addr[1:0].
  - SH/LH: be = 4'b0011 << addr[1:0].
  - SW/LW: be = 4'b1111.
- Store data: SB replicates byte ×4; SH replicates half ×2.
- Load extension:
  - Selected lane of bus_rdata, shifted right by 8·addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- No request (both strobes low): no bus activity, cpu_stall=0.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro:
  - A counter runs in BUSY, cleared on entry.
  - After TIMEOUT_CYCLES BUSY cycles without bus_ready: drop bus_valid, go to ERR (cpu_err pulse).
  - A late bus_ready after abandonment is ignored in IDLE.
- Without the macro: no counter logic; BUSY waits indefinitely.

Decomposition:
- Package dmem_bus_pkg holds:
  - FSM state enum.
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - TIMEOUT_CYCLES default.
- Sub-module lsu_lane_align (combinational), covering:
  - Alignment check and legality.
  - Byte-enable generation.
  - Store replication.
  - Load shift and extension.
- The FSM and bus registers stay in dmem_bus_bridge.

Test Plan:
- LW addr 0x100, bus_ready in first BUSY cycle, bus_rdata 0xDEADBEEF → bus_be=1111, bus_addr=0x100; stall in cycles 0–1; DONE cycle 2 with cpu_rdata=0xDEADBEEF.
- LB addr 0x103, rdata 0x80112233 → be=1000, cpu_rdata=0xFFFFFF80. LBU same → 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD, 3 wait states → bus_we=1, be=1100, bus_addr=0x200, bus_wdata=0xABCDABCD; bus outputs stable across waits; stall released after 5 cycles.
- LW addr 0x101 → no bus_valid; ERR cycle: cpu_err=1, stall=0, cpu_rdata=0.
- rst_n pulled low mid-BUSY → bus_valid=0 immediately (asynchronously), state=IDLE; a fresh SW to 0x300 completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready tied low → bus_valid high for 4 cycles, then cpu_err pulse, IDLE.
